// File: rtl/ucode_seq.sv
// ucode_seq: microcode address sequencer with prioritised interrupt entry, return stack and WAI/STP halt.
// Ports:
//    clk, reset (async, active-low), rdy (0 freezes state)
//    DB opcode/data bus, D decimal half select, I global IRQ mask, nmi rising-edge NMI
//    irq/irq_en level IRQ sources and enables (irq[0] highest priority)
//    seq_op/nxt/fin/we_nxt control fields from the registered microcode ROM
//    upc next microcode address, rom_en ROM enable, sync FETCH marker, WE registered write enable
//    vec_id last source taken, halt WAIT/STOP, stk_err sticky stack fault
module ucode_seq #(
   parameter int DB_W = 8,
   parameter int FIN_W = 5,
   parameter int NIRQ = 2,
   parameter int STK_DEPTH = 2,
   parameter logic [DB_W:0] RESET_UPC = 9'h1F0,
   parameter logic [DB_W:0] INT_BASE = 9'h160,
   parameter int INT_STRIDE = 8,
   parameter logic [DB_W-1:0] WAI_OP = 8'hCB,
   parameter logic [DB_W-1:0] STP_OP = 8'hDB
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rdy,
   input  logic [DB_W-1:0] DB,
   input  logic            D,
   input  logic            I,
   input  logic            nmi,
   input  logic [NIRQ-1:0] irq,
   input  logic [NIRQ-1:0] irq_en,
   input  logic [2:0]      seq_op,
   input  logic [DB_W-2:0] nxt,
   input  logic [FIN_W-1:0] fin,
   input  logic            we_nxt,
   output logic [DB_W:0]   upc,
   output logic            rom_en,
   output logic            sync,
   output logic            WE,
   output logic [1:0]      vec_id,
   output logic            halt,
   output logic            stk_err
);
   localparam int UPC_W = DB_W + 1;
   localparam int FX_W = UPC_W - 4;
   localparam int SP_W = $clog2(STK_DEPTH + 1);
   typedef enum logic [1:0] {S_RUN, S_WAIT, S_STOP} hstate_t;
   hstate_t hs_q, hs_d;
   logic [UPC_W-1:0] upc_q, upc_d, stk_top, vec_addr;
   logic [UPC_W-1:0] stk_q [STK_DEPTH];
   logic [UPC_W-1:0] stk_d [STK_DEPTH];
   logic [SP_W-1:0] sp_q, sp_d;
   logic [FIN_W-1:0] finish_q, finish_d;
   logic [FX_W-1:0] fin_ext;
   logic [1:0] vec_q, vec_d, irq_k, vec_k;
   logic start_q, start_d, we_q, we_d, err_q, err_d, np_q, np_d, nmi_q;
   logic [NIRQ-1:0] irq_hit;
   logic irq_any, pend, ret_uf, fetch, en, take, push, pop, full;
   assign halt = hs_q != S_RUN;
   assign rom_en = rdy & ~halt;
   assign sync = seq_op == 3'd0;
   assign WE = we_q;
   assign vec_id = vec_q;
   assign stk_err = err_q;
   always_comb begin
      irq_hit = irq & irq_en;
      irq_k = '0;
      irq_any = 1'b0;
      for (int i = NIRQ - 1; i >= 0; i--)
         if (irq_hit[i] && !I) begin
            irq_any = 1'b1;
            irq_k = 2'(i + 1);
         end
      pend = np_q | irq_any;
      vec_k = np_q ? 2'd0 : irq_k;
      vec_addr = UPC_W'(int'(INT_BASE) + int'(vec_k) * INT_STRIDE);
      full = sp_q == SP_W'(STK_DEPTH);
      // RET on an empty stack degrades to an ordinary FETCH
      ret_uf = seq_op == 3'd5 && sp_q == '0;
      fetch = seq_op == 3'd0 || ret_uf;
      stk_top = stk_q[0];
      for (int i = 0; i < STK_DEPTH; i++)
         if (sp_q == SP_W'(i + 1)) stk_top = stk_q[i];
      fin_ext = FX_W'(finish_q);
      upc = start_q ? RESET_UPC :
            fetch ? (pend ? vec_addr : {1'b0, DB}) :
            seq_op == 3'd2 ? {1'b1, D, 2'b10, fin_ext} :
            seq_op == 3'd5 ? stk_top : {1'b1, D, nxt};
      // the first enabled edge after reset only loads RESET_UPC; the control fields are not yet valid
      en = rom_en & ~start_q;
      take = en & fetch & pend;
      push = en && seq_op == 3'd4;
      pop = en && seq_op == 3'd5 && !ret_uf;
      upc_d = rom_en ? upc : upc_q;
      start_d = start_q & ~rom_en;
      we_d = en ? we_nxt : we_q;
      finish_d = en && seq_op == 3'd3 ? fin : finish_q;
      vec_d = take ? vec_k : vec_q;
      // a fresh edge in the clearing cycle wins over the clear
      np_d = (nmi & ~nmi_q) | (np_q & ~take);
      err_d = err_q | (push & full) | (en & ret_uf);
      sp_d = push && !full ? sp_q + SP_W'(1) : pop ? sp_q - SP_W'(1) : sp_q;
      stk_d = stk_q;
      for (int i = 0; i < STK_DEPTH; i++)
         if (push && !full && sp_q == SP_W'(i)) stk_d[i] = upc_q + UPC_W'(1);
      hs_d = hs_q;
      if (en && fetch && !pend) hs_d = DB == WAI_OP ? S_WAIT : DB == STP_OP ? S_STOP : S_RUN;
      // wake ignores I and rdy; the resumed FETCH decides whether to vector
      if (hs_q == S_WAIT && (np_q || |irq_hit)) hs_d = S_RUN;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         hs_q <= S_RUN;
         upc_q <= RESET_UPC;
         stk_q <= '{default: '0};
         sp_q <= '0;
         finish_q <= '0;
         vec_q <= '0;
         start_q <= 1'b1;
         we_q <= 1'b0;
         err_q <= 1'b0;
         np_q <= 1'b0;
         nmi_q <= 1'b0;
      end else begin
         hs_q <= hs_d;
         upc_q <= upc_d;
         stk_q <= stk_d;
         sp_q <= sp_d;
         finish_q <= finish_d;
         vec_q <= vec_d;
         start_q <= start_d;
         we_q <= we_d;
         err_q <= err_d;
         np_q <= np_d;
         nmi_q <= nmi;
      end
endmodule

// File: tb/tb_ucode_seq.sv
// tb_ucode_seq: directed and random checks of ucode_seq against a behavioural model.
module tb_ucode_seq;
   logic clk = 1'b0;
   logic reset, rdy, D, I, nmi, we_nxt;
   logic [7:0] DB;
   logic [1:0] irq, irq_en;
   logic [2:0] seq_op;
   logic [6:0] nxt;
   logic [4:0] fin;
   logic [8:0] upc;
   logic rom_en, sync, WE, halt, stk_err;
   logic [1:0] vec_id;
   int n_tests = 0;
   int n_fail = 0;
   int m_upcq, m_fin, m_vec, m_mode;
   bit m_start, m_we, m_np, m_nprev, m_err;
   int m_stk[$];
   always #5 clk = ~clk;
   ucode_seq dut (
      .clk(clk), .reset(reset), .rdy(rdy), .DB(DB), .D(D), .I(I), .nmi(nmi),
      .irq(irq), .irq_en(irq_en), .seq_op(seq_op), .nxt(nxt), .fin(fin), .we_nxt(we_nxt),
      .upc(upc), .rom_en(rom_en), .sync(sync), .WE(WE), .vec_id(vec_id), .halt(halt), .stk_err(stk_err)
   );
   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic m_reset();
      m_start = 1;
      m_upcq = 'h1F0;
      m_fin = 0;
      m_vec = 0;
      m_mode = 0;
      m_we = 0;
      m_np = 0;
      m_nprev = 0;
      m_err = 0;
      m_stk.delete();
   endtask
   function automatic int m_k();
      if (m_np) return 0;
      for (int i = 0; i < 2; i++) if (irq[i] && irq_en[i] && !I) return i + 1;
      return -1;
   endfunction
   function automatic int m_op();
      return seq_op > 5 ? 1 : int'(seq_op);
   endfunction
   function automatic int m_upc();
      int k;
      k = m_k();
      if (m_start) return 'h1F0;
      if (m_op() == 0 || (m_op() == 5 && m_stk.size() == 0)) return k >= 0 ? 'h160 + 8 * k : int'(DB);
      if (m_op() == 2) return 'h140 | (int'(D) << 7) | m_fin;
      if (m_op() == 5) return m_stk[$];
      return 'h100 | (int'(D) << 7) | int'(nxt);
   endfunction
   task automatic m_step();
      int u, k, op;
      bit edge_n, fl;
      u = m_upc();
      k = m_k();
      op = m_op();
      edge_n = nmi && !m_nprev;
      m_nprev = nmi;
      if (m_mode == 1 && (m_np || (irq & irq_en) != 0)) m_mode = 0;
      else if (rdy && m_mode == 0) begin
         if (!m_start) begin
            fl = op == 0 || (op == 5 && m_stk.size() == 0);
            m_we = we_nxt;
            if (op == 3) m_fin = int'(fin);
            if (fl && k >= 0) begin
               m_vec = k;
               if (k == 0) m_np = 0;
            end
            if (fl && k < 0 && DB == 8'hCB) m_mode = 1;
            if (fl && k < 0 && DB == 8'hDB) m_mode = 2;
            if (op == 4) begin
               if (m_stk.size() < 2) m_stk.push_back((m_upcq + 1) & 'h1FF);
               else m_err = 1;
            end
            if (op == 5) begin
               if (m_stk.size() > 0) void'(m_stk.pop_back());
               else m_err = 1;
            end
         end
         m_start = 0;
         m_upcq = u;
      end
      if (edge_n) m_np = 1;
   endtask
   task automatic check_all();
      chk("upc", int'(upc), m_upc());
      chk("rom_en", int'(rom_en), int'(rdy && m_mode == 0));
      chk("sync", int'(sync), int'(seq_op == 0));
      chk("WE", int'(WE), int'(m_we));
      chk("vec_id", int'(vec_id), m_vec);
      chk("halt", int'(halt), int'(m_mode != 0));
      chk("stk_err", int'(stk_err), int'(m_err));
   endtask
   task automatic step();
      #1 check_all();
      @(posedge clk);
      m_step();
      #1;
   endtask
   task automatic do_reset(input bit async_chk);
      reset = 1'b0;
      m_reset();
      #1;
      if (async_chk) begin
         chk("rst_halt", int'(halt), 0);
         chk("rst_upc", int'(upc), 'h1F0);
      end
      @(posedge clk);
      #1 check_all();
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask
   initial begin
      rdy = 1; D = 0; I = 0; nmi = 0; irq = 0; irq_en = 0;
      seq_op = 0; nxt = 0; fin = 0; we_nxt = 0; DB = 8'hA9;
      do_reset(0);
      step();
      chk("t1_upc", int'(upc), 'h0A9);
      chk("t1_we", int'(WE), 0);
      chk("t1_halt", int'(halt), 0);
      seq_op = 1; irq = 2'b01; irq_en = 2'b01; nmi = 1;
      step();
      nmi = 0; seq_op = 0;
      #1 chk("t2_nmi_upc", int'(upc), 'h160);
      step();
      chk("t2_nmi_vec", int'(vec_id), 0);
      #1 chk("t2_irq_upc", int'(upc), 'h168);
      step();
      chk("t2_irq_vec", int'(vec_id), 1);
      I = 1;
      #1 chk("t2_masked", int'(upc), 'h0A9);
      step();
      irq = 0; I = 0; seq_op = 1; nxt = 7'h05;
      step();
      seq_op = 4; nxt = 7'h20;
      #1 chk("t3_call", int'(upc), 'h120);
      step();
      nxt = 7'h30;
      step();
      nxt = 7'h40;
      step();
      chk("t3_ovf", int'(stk_err), 1);
      seq_op = 5;
      step();
      #1 chk("t3_ret", int'(upc), 'h106);
      step();
      #1 chk("t3_uf_upc", int'(upc), 'h0A9);
      step();
      chk("t3_err_held", int'(stk_err), 1);
      seq_op = 0; DB = 8'hCB;
      step();
      chk("t4_halt", int'(halt), 1);
      chk("t4_rom_en", int'(rom_en), 0);
      irq = 2'b10; irq_en = 2'b10; I = 1;
      step();
      chk("t4_wake", int'(halt), 0);
      DB = 8'h42;
      #1 chk("t4_resume", int'(upc), 'h042);
      step();
      DB = 8'hDB;
      step();
      chk("t5_stop", int'(halt), 1);
      nmi = 1;
      step();
      nmi = 0; irq = 2'b01; irq_en = 2'b01; I = 0;
      step();
      step();
      chk("t5_stop_held", int'(halt), 1);
      do_reset(1);
      irq = 0; irq_en = 0; seq_op = 1; we_nxt = 1;
      step();
      step();
      chk("t6_we_set", int'(WE), 1);
      rdy = 0; seq_op = 3;
      for (int i = 0; i < 3; i++) begin
         we_nxt = ~we_nxt;
         nmi = i == 1;
         fin = 5'($urandom);
         step();
         chk("t6_we_frozen", int'(WE), 1);
      end
      nmi = 0; rdy = 1; seq_op = 0; DB = 8'h11;
      #1 chk("t6_nmi_upc", int'(upc), 'h160);
      step();
      for (int c = 0; c < 1500; c++) begin
         rdy = $urandom_range(0, 9) != 0;
         seq_op = 3'($urandom);
         DB = $urandom_range(0, 9) == 0 ? 8'hCB : $urandom_range(0, 199) == 0 ? 8'hDB : 8'($urandom);
         D = 1'($urandom);
         I = 1'($urandom);
         nmi = $urandom_range(0, 7) == 0;
         irq = $urandom_range(0, 5) == 0 ? 2'($urandom) : 2'b00;
         irq_en = 2'($urandom);
         nxt = 7'($urandom);
         fin = 5'($urandom);
         we_nxt = 1'($urandom);
         if ($urandom_range(0, 199) == 0) do_reset(1);
         else step();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
